// File: rtl/ad1868_pkg.sv
// Shared types for the AD1868 serial receiver.
// Sample width and framer FSM states.
package ad1868_pkg;

  localparam int AD1868_WIDTH = 18;

  typedef enum logic {
    SEEK,
    RUN
  } state_t;

  typedef logic [AD1868_WIDTH-1:0] sample_t;

endpackage

// File: rtl/ad1868_pin_sync.sv
// Async pin synchroniser with a registered rising-edge pulse.
// Pulse appears SYNC_STAGES+1 cycles after the pin edge.
module ad1868_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign o_rise = rise_q;

endmodule

// File: rtl/ad1868_rx_framer.sv
// AD1868 serial bus deserialiser feeding the I2S encoder.
// Optional bit-count checking: define AD1868_RX_BITCOUNT_EN.
import ad1868_pkg::*;

module ad1868_rx_framer #(
  parameter int WIDTH       = AD1868_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ad_bck,
  input  logic             i_ad_wdclk,
  input  logic             i_ad_data_l,
  input  logic             i_ad_data_r,
  input  logic             i_i2s_latch,
  output logic [WIDTH-1:0] o_data_l,
  output logic [WIDTH-1:0] o_data_r,
  output logic             o_pending,
  output logic             o_overrun,
  output logic             o_err
);

  logic rise_bck;
  logic rise_wd;

  ad1868_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bck (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_ad_bck),
    .o_rise (rise_bck)
  );

  ad1868_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wd (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_ad_wdclk),
    .o_rise (rise_wd)
  );

  logic [SYNC_STAGES-1:0] dl_sync_q, dl_sync_d;
  logic [SYNC_STAGES-1:0] dr_sync_q, dr_sync_d;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shift_l_q, shift_l_d;
  logic [WIDTH-1:0]       shift_r_q, shift_r_d;
  logic [WIDTH-1:0]       hold_l_q, hold_l_d;
  logic [WIDTH-1:0]       hold_r_q, hold_r_d;
  logic [WIDTH-1:0]       data_l_q, data_l_d;
  logic [WIDTH-1:0]       data_r_q, data_r_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   capture;
  logic                   take;

`ifdef AD1868_RX_BITCOUNT_EN
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] bit_cnt_inc;
  logic       err_q, err_d;
`endif

  always_comb begin
    dl_sync_d = {dl_sync_q[SYNC_STAGES-2:0], i_ad_data_l};
    dr_sync_d = {dr_sync_q[SYNC_STAGES-2:0], i_ad_data_r};
    state_d   = state_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    data_l_d  = data_l_q;
    data_r_d  = data_r_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    capture   = rise_wd && (state_q == RUN);
    take      = i_i2s_latch && pending_q;

    if (rise_bck) begin
      shift_l_d = {shift_l_q[WIDTH-2:0], dl_sync_q[SYNC_STAGES-1]};
      shift_r_d = {shift_r_q[WIDTH-2:0], dr_sync_q[SYNC_STAGES-1]};
    end

    if (rise_wd) begin
      state_d = RUN;
    end

    // capture uses the post-shift value so a coincident BCK bit is kept
    if (capture) begin
      hold_l_d = shift_l_d;
      hold_r_d = shift_r_d;
    end

    if (take) begin
      data_l_d  = hold_l_q;
      data_r_d  = hold_r_q;
      pending_d = 1'b0;
    end

    if (capture) begin
      pending_d = 1'b1;
      if (pending_q && !take) begin
        overrun_d = 1'b1;
      end
    end
  end

`ifdef AD1868_RX_BITCOUNT_EN
  always_comb begin
    bit_cnt_inc = bit_cnt_q;
    if (rise_bck && bit_cnt_q != 5'd31) begin
      bit_cnt_inc = bit_cnt_q + 5'd1;
    end
    bit_cnt_d = rise_wd ? 5'd0 : bit_cnt_inc;
    err_d     = err_q;
    if (capture && bit_cnt_inc != 5'(WIDTH)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dl_sync_q <= '0;
      dr_sync_q <= '0;
      state_q   <= SEEK;
      shift_l_q <= '0;
      shift_r_q <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      data_l_q  <= '0;
      data_r_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dl_sync_q <= dl_sync_d;
      dr_sync_q <= dr_sync_d;
      state_q   <= state_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      data_l_q  <= data_l_d;
      data_r_q  <= data_r_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data_l  = data_l_q;
  assign o_data_r  = data_r_q;
  assign o_pending = pending_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_ad1868_rx_framer.sv
// Scoreboard bench for ad1868_rx_framer.
// Build with AD1868_RX_BITCOUNT_EN to also exercise the bit-count flag.
module tb_ad1868_rx_framer;

  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic        bck;
  logic        wd;
  logic        dl;
  logic        dr;
  logic        latch;
  logic [17:0] dol;
  logic [17:0] dor;
  logic        pend;
  logic        ovr;
  logic        err;

  ad1868_rx_framer #(.WIDTH(18), .SYNC_STAGES(S)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ad_bck    (bck),
    .i_ad_wdclk  (wd),
    .i_ad_data_l (dl),
    .i_ad_data_r (dr),
    .i_i2s_latch (latch),
    .o_data_l    (dol),
    .o_data_r    (dor),
    .o_pending   (pend),
    .o_overrun   (ovr),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] l;
    logic [17:0] r;
  } smp_t;

  smp_t        sb[$];
  smp_t        s;
  logic [17:0] ml, mr;
  logic [17:0] mdl, mdr;
  logic        mrun, mpend, movr, merr;
  int          checks = 0;
  int          bad = 0;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bck = 1'b0;
    wd = 1'b0;
    dl = 1'b0;
    dr = 1'b0;
    latch = 1'b0;
    clk_n(3);
    rst = 1'b0;
    clk_n(1);
    ml = '0; mr = '0; mdl = '0; mdr = '0;
    mrun = 1'b0; mpend = 1'b0; movr = 1'b0; merr = 1'b0;
    sb.delete();
  endtask

  task automatic send_bits(input logic [17:0] l, input logic [17:0] r,
                           input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dl = l[i];
      dr = r[i];
      clk_n(4);
      bck = 1'b1;
      ml = {ml[16:0], l[i]};
      mr = {mr[16:0], r[i]};
      clk_n(4);
      bck = 1'b0;
    end
  endtask

  task automatic send_word(input logic [17:0] l, input logic [17:0] r,
                           input int n, input bit lat);
    send_bits(l, r, n);
    clk_n(2);
    wd = 1'b1;
    clk_n(S + 1);
    checks++;
    if (pend !== mpend) begin
      bad++;
      $display("FAIL pend_pre_capture: got %b want %b", pend, mpend);
    end
    if (lat) latch = 1'b1;
    clk_n(1);
    latch = 1'b0;
    if (!mrun) begin
      mrun = 1'b1;
    end else begin
`ifdef AD1868_RX_BITCOUNT_EN
      if (n != 18) merr = 1'b1;
`endif
      if (lat && mpend) begin
        s = sb.pop_front();
        mdl = s.l;
        mdr = s.r;
      end else if (mpend) begin
        s = sb.pop_front();
        movr = 1'b1;
      end
      sb.push_back({ml, mr});
      mpend = 1'b1;
    end
    checks++;
    if (pend !== mpend) begin
      bad++;
      $display("FAIL pend_post_capture: got %b want %b", pend, mpend);
    end
    checks++;
    if (ovr !== movr) begin
      bad++;
      $display("FAIL overrun: got %b want %b", ovr, movr);
    end
    checks++;
    if (err !== merr) begin
      bad++;
      $display("FAIL err: got %b want %b", err, merr);
    end
    checks++;
    if (dol !== mdl || dor !== mdr) begin
      bad++;
      $display("FAIL data_at_capture: got %h/%h want %h/%h",
               dol, dor, mdl, mdr);
    end
    clk_n(2);
    wd = 1'b0;
    clk_n(4);
  endtask

  task automatic do_latch();
    latch = 1'b1;
    clk_n(1);
    latch = 1'b0;
    if (mpend) begin
      s = sb.pop_front();
      mdl = s.l;
      mdr = s.r;
      mpend = 1'b0;
    end
    checks++;
    if (dol !== mdl || dor !== mdr) begin
      bad++;
      $display("FAIL latch_data: got %h/%h want %h/%h", dol, dor, mdl, mdr);
    end
    checks++;
    if (pend !== 1'b0) begin
      bad++;
      $display("FAIL latch_pend: got %b want 0", pend);
    end
    clk_n(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dol, dor, pend, ovr, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%h %b%b%b want all 0",
               dol, dor, pend, ovr, err);
    end
  endtask

  task automatic test_seek();
    send_word(18'h2AAAA, 18'h15555, 18, 1'b0);
    do_latch();
    checks++;
    if (pend !== 1'b0 || dol !== 18'h0 || dor !== 18'h0) begin
      bad++;
      $display("FAIL seek_no_capture: got %b %h/%h want 0 0/0",
               pend, dol, dor);
    end
  endtask

  task automatic test_capture();
    send_word(18'h3FFFF, 18'h00001, 18, 1'b0);
    do_latch();
    checks++;
    if (dol !== 18'h3FFFF || dor !== 18'h00001) begin
      bad++;
      $display("FAIL capture_data: got %h/%h want 3ffff/00001", dol, dor);
    end
  endtask

  task automatic test_latch_same();
    send_word(18'h12345, 18'h0ABCD, 18, 1'b0);
    send_word(18'h2F0F0, 18'h10F0F, 18, 1'b1);
    checks++;
    if (dol !== 18'h12345 || dor !== 18'h0ABCD || pend !== 1'b1 ||
        ovr !== 1'b0) begin
      bad++;
      $display("FAIL latch_same: got %h/%h p%b o%b want 12345/0abcd p1 o0",
               dol, dor, pend, ovr);
    end
    do_latch();
    checks++;
    if (dol !== 18'h2F0F0 || dor !== 18'h10F0F) begin
      bad++;
      $display("FAIL latch_same_next: got %h/%h want 2f0f0/10f0f", dol, dor);
    end
  endtask

  task automatic test_no_pending();
    do_latch();
    checks++;
    if (dol !== 18'h2F0F0 || dor !== 18'h10F0F) begin
      bad++;
      $display("FAIL no_pending_hold: got %h/%h want 2f0f0/10f0f", dol, dor);
    end
  endtask

  task automatic test_overrun();
    send_word(18'h11111, 18'h22222, 18, 1'b0);
    send_word(18'h33333, 18'h04444, 18, 1'b0);
    do_latch();
    checks++;
    if (dol !== 18'h33333 || dor !== 18'h04444 || ovr !== 1'b1) begin
      bad++;
      $display("FAIL overrun_deliver: got %h/%h o%b want 33333/04444 o1",
               dol, dor, ovr);
    end
  endtask

  task automatic test_bitcount();
    do_reset();
    send_word(18'h3C3C3, 18'h0F0F0, 18, 1'b0);
    send_word(18'h0BEEF, 18'h0CAFE, 16, 1'b0);
`ifdef AD1868_RX_BITCOUNT_EN
    checks++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_short_word: got %b want 1", err);
    end
`endif
    do_latch();
    send_word(18'h25A5A, 18'h1A5A5, 18, 1'b0);
    do_latch();
    do_reset();
    checks++;
    if (err !== 1'b0 || ovr !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared: got e%b o%b want e0 o0", err, ovr);
    end
  endtask

  task automatic test_mid_reset();
    send_bits(18'h3FFFF, 18'h3FFFF, 7);
    do_reset();
    send_word(18'h01234, 18'h04321, 18, 1'b0);
    checks++;
    if (pend !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_seek: got %b want 0", pend);
    end
    send_word(18'h2468A, 18'h13579, 18, 1'b0);
    do_latch();
  endtask

  initial begin
    test_reset();
    test_seek();
    test_capture();
    test_latch_same();
    test_no_pending();
    test_overrun();
    test_bitcount();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
